// File: rtl/norm_pkg.sv
// Shared constants and the value-class encoding for the normaliser pipeline.
package norm_pkg;

    // Rounding modes
    localparam logic RM_RNE = 1'b0;
    localparam logic RM_RTZ = 1'b1;

    // Bit positions inside the 4-bit flags output {of, uf, nx, zero}
    localparam int FLG_OF   = 3;
    localparam int FLG_UF   = 2;
    localparam int FLG_NX   = 1;
    localparam int FLG_ZERO = 0;

    // Classification of the raw adder result, decided in stage 1
    typedef enum logic [1:0] {
        CLS_CARRY  = 2'd0,  // carry bit set: shift right by one
        CLS_NORM   = 2'd1,  // hidden bit set: already normalised
        CLS_LSHIFT = 2'd2,  // leading one below hidden: shift left
        CLS_ZERO   = 2'd3   // whole working value is zero
    } norm_class_e;

endpackage

// File: rtl/norm_lzc.sv
// Combinational leading-zero counter. count == W when the input is all zero.
module norm_lzc #(
    parameter int W  = 28,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  value,
    output logic [CW-1:0] count,
    output logic          all_zero
);

    // Scan LSB to MSB so the highest set bit writes the count last
    always_comb begin
        count = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (value[i]) count = CW'(W - 1 - i);
        end
    end

    assign all_zero = ~|value;

endmodule

// File: rtl/norm_pipe.sv
// Three-stage normalise/round pipeline: classify, shift + underflow, round + overflow.
//
// Handshake: a beat transfers on the input when in_valid & in_ready, and on the
// output when out_valid & out_ready. All three stages advance together on
// en = ~out_valid | out_ready; when en is low every stage holds, so the output
// is stable while stalled and bubbles are kept. in_ready is simply en.
module norm_pipe
    import norm_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              rm,
    input  logic [EXP_W-1:0]  exp_in,
    input  logic [FRAC_W+1:0] frac_in,
    input  logic [2:0]        grs_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [EXP_W-1:0]  exp_out,
    output logic [FRAC_W-1:0] frac_out,
    output logic [3:0]        flags
);

    localparam int MW = FRAC_W + 5;          // {carry, hidden, frac, g, r, s}
    localparam int NW = FRAC_W + 4;          // {hidden, frac, g, r, s} after normalising
    localparam int CW = $clog2(FRAC_W + 6);  // leading-zero count width
    localparam int SW = EXP_W + 2;           // signed exponent working width
    localparam logic signed [SW-1:0] EXP_MAX = SW'((1 << EXP_W) - 1);

    logic en;
    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    // ---------------- stage 1: classify ----------------
    logic [MW-1:0] m;
    logic [CW-1:0] lzc_cnt;
    logic          lzc_zero;
    norm_class_e   cls_c;
    logic [CW-1:0] lz_c;

    assign m = {frac_in, grs_in};

    norm_lzc #(.W(MW), .CW(CW)) u_lzc (
        .value    (m),
        .count    (lzc_cnt),
        .all_zero (lzc_zero)
    );

    // Pick the class; lz is measured from the hidden position (one below MSB)
    always_comb begin
        cls_c = CLS_NORM;
        lz_c  = lzc_cnt - CW'(1);
        if (lzc_zero)          cls_c = CLS_ZERO;
        else if (m[MW-1])      cls_c = CLS_CARRY;
        else if (m[MW-2])      cls_c = CLS_NORM;
        else                   cls_c = CLS_LSHIFT;
    end

    logic             s1_valid;
    norm_class_e      s1_cls;
    logic [CW-1:0]    s1_lz;
    logic [EXP_W-1:0] s1_exp;
    logic [MW-1:0]    s1_m;
    logic             s1_rm;

    // ---------------- stage 2: shift, exponent adjust, underflow ----------------
    logic [MW-1:0]        sh_m;
    logic signed [SW-1:0] exp_adj;
    logic signed [SW-1:0] exp_ext;
    logic signed [SW-1:0] lz_ext;
    logic                 flush_c;

    // Apply the shift chosen in stage 1; a right shift folds R|S into sticky
    always_comb begin
        exp_ext = {2'b00, s1_exp};
        lz_ext  = {{(SW-CW){1'b0}}, s1_lz};
        sh_m    = s1_m;
        exp_adj = exp_ext;
        flush_c = 1'b0;
        case (s1_cls)
            CLS_CARRY: begin
                sh_m    = {1'b0, s1_m[MW-1:3], s1_m[2], s1_m[1] | s1_m[0]};
                exp_adj = exp_ext + SW'(1);
            end
            CLS_LSHIFT: begin
                sh_m    = s1_m << s1_lz;
                exp_adj = exp_ext - lz_ext;
                flush_c = (lz_ext >= exp_ext);
            end
            default: ;
        endcase
    end

    logic                 s2_valid;
    logic [NW-1:0]        s2_m;
    logic signed [SW-1:0] s2_exp;
    logic                 s2_flush;
    logic                 s2_zero;
    logic                 s2_rm;

    // ---------------- stage 3: round, overflow, flags ----------------
    logic                 g_b, r_b, s_b, inc;
    logic                 frac_cy;
    logic [FRAC_W-1:0]    frac_r;
    logic signed [SW-1:0] exp_r;
    logic [EXP_W-1:0]     exp_n;
    logic [FRAC_W-1:0]    frac_n;
    logic [3:0]           flags_n;

    // Round the normalised mantissa, then resolve zero/flush/overflow outcomes
    always_comb begin
        g_b = s2_m[2];
        r_b = s2_m[1];
        s_b = s2_m[0];
        inc = (s2_rm == RM_RNE) & g_b & (r_b | s_b | s2_m[3]);
        {frac_cy, frac_r} = {1'b0, s2_m[NW-2:3]} + {{FRAC_W{1'b0}}, inc};
        // Mantissa carry-out only happens when the hidden bit is also set
        exp_r   = s2_exp + {{(SW-1){1'b0}}, frac_cy & s2_m[NW-1]};
        exp_n   = exp_r[EXP_W-1:0];
        frac_n  = frac_r;
        flags_n = 4'b0000;
        flags_n[FLG_NX] = g_b | r_b | s_b;
        if (s2_zero) begin
            exp_n   = '0;
            frac_n  = '0;
            flags_n = 4'b0000;
            flags_n[FLG_ZERO] = 1'b1;
        end else if (s2_flush) begin
            exp_n   = '0;
            frac_n  = '0;
            flags_n = 4'b0000;
            flags_n[FLG_UF] = 1'b1;
        end else if (exp_r >= EXP_MAX) begin
            exp_n   = '1;
            frac_n  = '0;
            flags_n = 4'b0000;
            flags_n[FLG_OF] = 1'b1;
            flags_n[FLG_NX] = 1'b1;
        end
    end

    // All three register banks advance together on the shared enable
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_cls    <= CLS_ZERO;
            s1_lz     <= '0;
            s1_exp    <= '0;
            s1_m      <= '0;
            s1_rm     <= RM_RNE;
            s2_valid  <= 1'b0;
            s2_m      <= '0;
            s2_exp    <= '0;
            s2_flush  <= 1'b0;
            s2_zero   <= 1'b0;
            s2_rm     <= RM_RNE;
            out_valid <= 1'b0;
            exp_out   <= '0;
            frac_out  <= '0;
            flags     <= '0;
        end else if (en) begin
            s1_valid  <= in_valid;
            s1_cls    <= cls_c;
            s1_lz     <= lz_c;
            s1_exp    <= exp_in;
            s1_m      <= m;
            s1_rm     <= rm;
            s2_valid  <= s1_valid;
            s2_m      <= sh_m[NW-1:0];
            s2_exp    <= exp_adj;
            s2_flush  <= flush_c;
            s2_zero   <= (s1_cls == CLS_ZERO);
            s2_rm     <= s1_rm;
            out_valid <= s2_valid;
            exp_out   <= exp_n;
            frac_out  <= frac_n;
            flags     <= flags_n;
        end
    end

endmodule

// File: tb/tb_norm_pipe.sv
// Directed testbench for norm_pipe with EXP_W=8, FRAC_W=23.
module tb_norm_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        rm;
    logic [7:0]  exp_in;
    logic [24:0] frac_in;
    logic [2:0]  grs_in;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  exp_out;
    logic [22:0] frac_out;
    logic [3:0]  flags;

    int n_cmp = 0;
    int n_err = 0;

    // expected {exp, frac, flags}
    logic [34:0] exp_q[$];

    norm_pipe #(.EXP_W(8), .FRAC_W(23)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rm        (rm),
        .exp_in    (exp_in),
        .frac_in   (frac_in),
        .grs_in    (grs_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .exp_out   (exp_out),
        .frac_out  (frac_out),
        .flags     (flags)
    );

    // clock / reset
    always #5 clk = ~clk;

    // Four beats reused by the back-to-back and stall scenarios
    logic [7:0]  bb_exp  [4];
    logic [24:0] bb_frac [4];
    logic [2:0]  bb_grs  [4];
    logic [34:0] bb_res  [4];

    task automatic init_beats();
        bb_exp[0] = 8'd25;  bb_frac[0] = 25'h1DF2DF2; bb_grs[0] = 3'b000; bb_res[0] = {8'd26,  23'h6F96F9, 4'b0000};
        bb_exp[1] = 8'd25;  bb_frac[1] = 25'h05F2DF2; bb_grs[1] = 3'b000; bb_res[1] = {8'd24,  23'h3E5BE4, 4'b0000};
        bb_exp[2] = 8'd100; bb_frac[2] = 25'h0FFFFFF; bb_grs[2] = 3'b100; bb_res[2] = {8'd101, 23'h000000, 4'b0010};
        bb_exp[3] = 8'd254; bb_frac[3] = 25'h1000000; bb_grs[3] = 3'b000; bb_res[3] = {8'd255, 23'h000000, 4'b1010};
    endtask

    // driver: send one beat with out_ready=1 and capture its result
    task automatic do_beat(input logic [7:0] e, input logic [24:0] f, input logic [2:0] g,
                           input logic r, output logic [7:0] eo, output logic [22:0] fo,
                           output logic [3:0] fl, output int lat);
        int  waited;
        bit  got;
        @(negedge clk);
        exp_in = e; frac_in = f; grs_in = g; rm = r; in_valid = 1'b1;
        waited = 0;
        while (!in_ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
        end
        eo = exp_out; fo = frac_out; fl = flags;
        n_cmp++;
        if (!got) begin
            n_err++;
            $display("FAIL beat_timeout: out_valid=0 after 10 cycles, required 1");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; rm = 1'b0;
        exp_in = '0; frac_in = '0; grs_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (exp_out !== 8'd0) begin n_err++; $display("FAIL reset_exp_out: got %0d want 0", exp_out); end
        n_cmp++; if (frac_out !== 23'd0) begin n_err++; $display("FAIL reset_frac_out: got %h want 0", frac_out); end
        n_cmp++; if (flags !== 4'd0) begin n_err++; $display("FAIL reset_flags: got %b want 0000", flags); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_carry();
        logic [7:0] eo; logic [22:0] fo; logic [3:0] fl; int lat;
        do_beat(8'd25, 25'h1DF2DF2, 3'b000, 1'b0, eo, fo, fl, lat);
        n_cmp++; if (eo !== 8'd26) begin n_err++; $display("FAIL carry_exp: got %0d want 26", eo); end
        n_cmp++; if (fo !== 23'h6F96F9) begin n_err++; $display("FAIL carry_frac: got %h want 6f96f9", fo); end
        n_cmp++; if (fl !== 4'b0000) begin n_err++; $display("FAIL carry_flags: got %b want 0000", fl); end
        n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL carry_latency: got %0d want 3", lat); end
    endtask

    task automatic test_lshift();
        logic [7:0] eo; logic [22:0] fo; logic [3:0] fl; int lat;
        do_beat(8'd25, 25'h05F2DF2, 3'b000, 1'b0, eo, fo, fl, lat);
        n_cmp++; if (eo !== 8'd24) begin n_err++; $display("FAIL lshift_exp: got %0d want 24", eo); end
        n_cmp++; if (fo !== 23'h3E5BE4) begin n_err++; $display("FAIL lshift_frac: got %h want 3e5be4", fo); end
        n_cmp++; if (fl !== 4'b0000) begin n_err++; $display("FAIL lshift_flags: got %b want 0000", fl); end
    endtask

    task automatic test_round();
        logic [7:0] eo; logic [22:0] fo; logic [3:0] fl; int lat;
        do_beat(8'd100, 25'h0FFFFFF, 3'b100, 1'b0, eo, fo, fl, lat);
        n_cmp++; if (eo !== 8'd101) begin n_err++; $display("FAIL rne_exp: got %0d want 101", eo); end
        n_cmp++; if (fo !== 23'h000000) begin n_err++; $display("FAIL rne_frac: got %h want 000000", fo); end
        n_cmp++; if (fl !== 4'b0010) begin n_err++; $display("FAIL rne_flags: got %b want 0010", fl); end
        do_beat(8'd100, 25'h0FFFFFF, 3'b100, 1'b1, eo, fo, fl, lat);
        n_cmp++; if (eo !== 8'd100) begin n_err++; $display("FAIL rtz_exp: got %0d want 100", eo); end
        n_cmp++; if (fo !== 23'h7FFFFF) begin n_err++; $display("FAIL rtz_frac: got %h want 7fffff", fo); end
        n_cmp++; if (fl !== 4'b0010) begin n_err++; $display("FAIL rtz_flags: got %b want 0010", fl); end
    endtask

    task automatic test_boundary();
        logic [7:0] eo; logic [22:0] fo; logic [3:0] fl; int lat;
        do_beat(8'd2, 25'h0000010, 3'b000, 1'b0, eo, fo, fl, lat);
        n_cmp++; if (eo !== 8'd0) begin n_err++; $display("FAIL uf_exp: got %0d want 0", eo); end
        n_cmp++; if (fo !== 23'h0) begin n_err++; $display("FAIL uf_frac: got %h want 0", fo); end
        n_cmp++; if (fl !== 4'b0100) begin n_err++; $display("FAIL uf_flags: got %b want 0100", fl); end
        do_beat(8'd254, 25'h1000000, 3'b000, 1'b0, eo, fo, fl, lat);
        n_cmp++; if (eo !== 8'd255) begin n_err++; $display("FAIL of_exp: got %0d want 255", eo); end
        n_cmp++; if (fo !== 23'h0) begin n_err++; $display("FAIL of_frac: got %h want 0", fo); end
        n_cmp++; if (fl !== 4'b1010) begin n_err++; $display("FAIL of_flags: got %b want 1010", fl); end
        do_beat(8'd77, 25'h0000000, 3'b000, 1'b0, eo, fo, fl, lat);
        n_cmp++; if (eo !== 8'd0) begin n_err++; $display("FAIL zero_exp: got %0d want 0", eo); end
        n_cmp++; if (fo !== 23'h0) begin n_err++; $display("FAIL zero_frac: got %h want 0", fo); end
        n_cmp++; if (fl !== 4'b0001) begin n_err++; $display("FAIL zero_flags: got %b want 0001", fl); end
    endtask

    task automatic test_back_to_back();
        int idx;
        int got;
        logic rdy;
        logic [34:0] e;
        idx = 0;
        rm = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back(bb_res[i]);
        // stalled phase: only three beats fit
        @(negedge clk);
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            if (idx < 4) begin
                exp_in = bb_exp[idx]; frac_in = bb_frac[idx]; grs_in = bb_grs[idx]; in_valid = 1'b1;
            end
            #1 rdy = in_ready;
            @(posedge clk);
            if (rdy) idx++;
        end
        @(negedge clk);
        n_cmp++; if (idx !== 3) begin n_err++; $display("FAIL stall_accepted: got %0d want 3", idx); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall_out_valid: got %b want 1", out_valid); end
        n_cmp++;
        if ({exp_out, frac_out, flags} !== bb_res[0]) begin
            n_err++;
            $display("FAIL stall_hold: got %h want %h", {exp_out, frac_out, flags}, bb_res[0]);
        end
        // drain phase
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 30; c++) begin
            if (c > 0) @(negedge clk);
            if (idx < 4) begin
                exp_in = bb_exp[idx]; frac_in = bb_frac[idx]; grs_in = bb_grs[idx]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1 rdy = in_ready;
            if (out_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL drain_extra: got %h want no beat", {exp_out, frac_out, flags});
                end else begin
                    e = exp_q.pop_front();
                    if ({exp_out, frac_out, flags} !== e) begin
                        n_err++;
                        $display("FAIL drain_beat%0d: got %h want %h", got, {exp_out, frac_out, flags}, e);
                    end
                end
                got++;
            end
            @(posedge clk);
            if (rdy && idx < 4) idx++;
            if (got == 4) break;
        end
        #1 in_valid = 1'b0;
        n_cmp++; if (got !== 4) begin n_err++; $display("FAIL drain_count: got %0d want 4", got); end
        exp_q.delete();
    endtask

    task automatic test_reset_stall();
        int seen;
        @(negedge clk);
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            exp_in = bb_exp[c]; frac_in = bb_frac[c]; grs_in = bb_grs[c]; in_valid = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rststall_pre: got %b want 1", out_valid); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rststall_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (flags !== 4'b0) begin n_err++; $display("FAIL rststall_flags: got %b want 0000", flags); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rststall_in_ready: got %b want 1", in_ready); end
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL rststall_discard: got %0d beats want 0", seen); end
    endtask

    initial begin
        init_beats();
        test_reset();
        test_carry();
        test_lshift();
        test_round();
        test_boundary();
        test_back_to_back();
        test_reset_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/norm_pipe.md
# norm_pipe

Parametrised, pipelined normaliser-and-rounder for the IEEE-754 datapath. Takes the raw adder result (exponent plus carry/hidden/fraction field with guard/round/sticky bits) and returns a normalised, rounded exponent/fraction pair with exception flags. It sits between the aligned mantissa adder and the result packer. It generalises the combinational normaliser with parametrised widths, rounding, and flags, plus a 3-stage valid/ready pipeline.

## Interface
- EXP_W, 8, exponent width
- FRAC_W, 23, stored fraction width (hidden bit excluded)
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts beat this cycle
- rm  in  1  rounding mode: 0 = RNE, 1 = RTZ
- exp_in  in  EXP_W  unbiased-field exponent (largest operand exponent)
- frac_in  in  FRAC_W+2  bit FRAC_W+1 = carry, bit FRAC_W = hidden, rest = fraction
- grs_in  in  3  guard, round, sticky bits below frac_in LSB
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- exp_out  out  EXP_W  normalised, rounded exponent
- frac_out  out  FRAC_W  normalised, rounded fraction (hidden bit dropped)
- flags  out  4  {of, uf, nx, zero}

## Operation
- Working value m = {frac_in, grs_in} (FRAC_W+5 bits). Exponent arithmetic is signed, EXP_W+2 bits.
- Stage 1: classify the value and compute the shift.
  - Carry set: shift right 1, exp+1. The bit shifted out of G goes to R, and R|S goes to S.
  - Hidden set: no shift.
  - Otherwise: lz = leading zeros counted from the hidden position over the full m. Shift left lz, exp−lz.
  - m == 0: zero class.
- Stage 2: apply the shift and the exponent adjust. Decide underflow.
  - Left-shift case with lz ≥ exp_in: flush to zero, exp_out=0, frac_out=0, uf=1.
  - Zero class: exp_out=0, frac_out=0, zero=1, uf=0, nx=0.
- Stage 3: round, then check overflow.
  - nx = G|R|S after the shift. nx is forced 0 on flush or zero.
  - RNE: increment when G & (R | S | lsb).
  - RTZ: never increment.
  - If the increment carries out of the mantissa: frac=0, exp+1.
  - Overflow: final exp ≥ 2^EXP_W−1 gives exp_out = all ones, frac_out = 0, of=1, nx=1.
- Flags are mutually consistent: zero and uf never set together; of excludes uf and zero.

## Timing
- Latency is 3 cycles from an accepted beat (in_valid & in_ready) to out_valid.
- Single global advance enable: en = ~out_valid | out_ready. in_ready = en.
- When en=0, all stage registers hold. Bubbles are not compressed. Holds up to 3 beats.
- Order is preserved. No beat is lost or duplicated under any out_ready pattern.
- Output is stable while out_valid & ~out_ready.
- Reset (synchronous, any cycle, including mid-stall): all stage valids = 0.
  - Reset values: out_valid=0, exp_out=0, frac_out=0, flags=0. in_ready=1 on the cycle after reset.
  - In-flight beats are discarded.
- in_valid with in_ready=0: the beat is not taken, and the source holds it.

## Structure
- Package norm_pkg holds:
  - rounding mode constants RM_RNE=0, RM_RTZ=1
  - flag bit indices FLG_OF=3, FLG_UF=2, FLG_NX=1, FLG_ZERO=0
  - the class encoding (CARRY, NORM, LSHIFT, ZERO)
- Sub-module norm_lzc: parametrised leading-zero counter, width FRAC_W+5, combinational. Output is a count of clog2(FRAC_W+6) bits, plus an all_zero flag.
- Top norm_pipe: the three pipeline register banks and the shared enable.

## Test plan
All scenarios use EXP_W=8, FRAC_W=23, grs=000 and rm=RNE unless stated.
- exp_in=25, frac_in=25'b1110111110010110111110010 -> exp_out=26, frac_out=23'h6F96F9, flags=0, out_valid exactly 3 cycles later.
- exp_in=25, frac_in=25'b0010111110010110111110010 -> exp_out=24, frac_out=23'h3E5BE4, flags=0.
- exp_in=100, frac_in=25'h0FFFFFF, grs=100:
  - RNE -> exp_out=101, frac_out=0, flags=0010 (nx).
  - RTZ -> exp_out=100, frac_out=23'h7FFFFF, flags=0010.
- Boundary values:
  - exp_in=2, frac_in=25'h0000010 -> exp_out=0, frac_out=0, flags=0100 (uf).
  - exp_in=254, frac_in=25'h1000000 -> exp_out=255, frac_out=0, flags=1010 (of, nx).
  - All-zero input -> flags=0001.
- Backpressure with out_ready=0, 4 back-to-back beats offered:
  - 3 are accepted; in_ready drops once out_valid=1.
  - On raising out_ready, all 4 results emerge in order.
  - rst asserted during the stall clears out_valid the next cycle.
